// File: rtl/hm_pkg.sv
// hm_pkg: widths and receive state shared by the Hamming(7,4) encoder, decoder and deframer.
package hm_pkg;
    localparam int unsigned CW_W   = 7;
    localparam int unsigned INFO_W = 4;
    typedef enum logic {HUNT, RECV} state_e;
endpackage

// File: rtl/hm_sync_detect.sv
// hm_sync_detect: sync-word shift register with a match flag on the value being shifted in.
module hm_sync_detect #(
    parameter int unsigned         SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = 8'hA5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic shift,
    input  logic bit_in,
    output logic hit
);
    logic [SYNC_LEN-1:0] sr_q, sr_d;
    assign sr_d = {sr_q[SYNC_LEN-2:0], bit_in};
    assign hit  = shift && !clr && (sr_d == SYNC_WORD);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else if (clr) sr_q <= '0;
        else if (shift) sr_q <= sr_d;
    end
endmodule

// File: rtl/hm_rx_deframer.sv
// hm_rx_deframer: hunts a sync word, then deframes 7-bit codewords into a valid/ready holding register.
module hm_rx_deframer
    import hm_pkg::*;
#(
    parameter int unsigned         SYNC_LEN    = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 8'hA5,
    parameter int unsigned         FRAME_WORDS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bit_in,
    input  logic            bit_valid,
    input  logic            resync,
    output logic [CW_W-1:0] cw_out,
    output logic            cw_valid,
    input  logic            cw_ready,
    output logic            cw_sof,
    output logic            locked,
    output logic            overflow,
    output logic [7:0]      frame_cnt
);
    state_e          state_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      word_idx_q;
    logic [CW_W-2:0] asm_q;
    logic [CW_W-1:0] cw_q;
    logic            cw_valid_q, cw_sof_q, overflow_q;
    logic [7:0]      frame_cnt_q;
    logic            rx_bit, word_done, load, last_word, sync_clr, hit;

    assign rx_bit    = (state_q == RECV) && bit_valid && !resync;
    assign word_done = rx_bit && (bit_idx_q == 3'd6);
    // A consumer taking the held word this cycle frees the slot for the word completing now.
    assign load      = word_done && (!cw_valid_q || cw_ready);
    assign last_word = word_idx_q == 8'(FRAME_WORDS - 1);
    assign sync_clr  = resync || (word_done && last_word);

    hm_sync_detect #(.SYNC_LEN(SYNC_LEN), .SYNC_WORD(SYNC_WORD)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sync_clr),
        .shift ((state_q == HUNT) && bit_valid),
        .bit_in(bit_in),
        .hit   (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            bit_idx_q   <= '0;
            word_idx_q  <= '0;
            asm_q       <= '0;
            cw_q        <= '0;
            cw_valid_q  <= 1'b0;
            cw_sof_q    <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            overflow_q <= word_done && !load;
            if (load) begin
                cw_q       <= {bit_in, asm_q};
                cw_sof_q   <= word_idx_q == '0;
                cw_valid_q <= 1'b1;
            end else if (cw_ready) begin
                cw_valid_q <= 1'b0;
            end
            if (resync) begin
                state_q    <= HUNT;
                bit_idx_q  <= '0;
                word_idx_q <= '0;
            end else if (state_q == HUNT) begin
                if (hit) begin
                    state_q    <= RECV;
                    bit_idx_q  <= '0;
                    word_idx_q <= '0;
                end
            end else if (bit_valid) begin
                // Bits arrive LSB first, so shifting right leaves bit 0 at asm_q[0] after six bits.
                asm_q <= {bit_in, asm_q[CW_W-2:1]};
                if (bit_idx_q == 3'd6) begin
                    bit_idx_q  <= '0;
                    word_idx_q <= word_idx_q + 8'd1;
                    if (last_word) begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        state_q     <= HUNT;
                        word_idx_q  <= '0;
                    end
                end else begin
                    bit_idx_q <= bit_idx_q + 3'd1;
                end
            end
        end
    end

    assign cw_out    = cw_q;
    assign cw_valid  = cw_valid_q;
    assign cw_sof    = cw_sof_q;
    assign locked    = state_q == RECV;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;
endmodule
